// File: rtl/pipe_ctrl_gen_if.sv
// Handshake bundle between the pipeline controller and the core top:
// stall/flush requests in, stall vector, flush, counter readout and watchdog out.
interface pipe_ctrl_gen_if #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_SRC    = 4,
  parameter int CNT_WIDTH  = 32
);
  localparam int SEL_W = $clog2(NUM_SRC + 1);

  logic                  except_en;
  logic [NUM_SRC-1:0]    stallreq;
  logic                  cnt_clr;
  logic [SEL_W-1:0]      cnt_sel;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  cnt_rdata;
  logic                  stall_timeout;

  modport master (
    output except_en, stallreq, cnt_clr, cnt_sel,
    input  stall, flush, cnt_rdata, stall_timeout
  );

  modport slave (
    input  except_en, stallreq, cnt_clr, cnt_sel,
    output stall, flush, cnt_rdata, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: merges per-stage stall requests into a
// thermometer stall vector, holds flush for FLUSH_CYCLES, and tracks stall statistics.
module pipe_ctrl_gen #(
  parameter int                   NUM_STAGES   = 6,
  parameter int                   NUM_SRC      = 4,
  parameter logic [3*NUM_SRC-1:0] SRC_STAGE    = 12'hB1A,
  parameter int                   CNT_WIDTH    = 32,
  parameter int                   TIMEOUT      = 1024,
  parameter int                   FLUSH_CYCLES = 1
) (
  input logic            clk,
  input logic            resetn,
  pipe_ctrl_gen_if.slave bus
);

  localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT);

  logic [HOLD_W-1:0]     hold_cnt;
  logic [WD_W-1:0]       wd_cnt;
  logic                  timeout_flag;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  src_cnt [NUM_SRC];
  logic [CNT_WIDTH-1:0]  src_nxt [NUM_SRC];
  logic [CNT_WIDTH-1:0]  total_cnt;
  logic [CNT_WIDTH-1:0]  total_nxt;
  logic [CNT_WIDTH-1:0]  rdata;
  logic [CNT_WIDTH-1:0]  rdata_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Deepest stalled stage wins; every stage upstream of it stalls too.
  always_comb begin
    int  idx;
    int  top;
    logic any;
    idx = 0;
    top = 0;
    any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.stallreq[i]) begin
        idx = int'(SRC_STAGE[3*i +: 3]);
        if (idx > NUM_STAGES - 1) idx = NUM_STAGES - 1;
        if (idx > top) top = idx;
        any = 1'b1;
      end
    end
    for (int j = 0; j < NUM_STAGES; j++) begin
      stall_raw[j] = any && (j <= top);
    end
  end

  assign flush = resetn && (bus.except_en || (hold_cnt != '0));
  assign stall = (resetn && !flush) ? stall_raw : '0;

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.cnt_rdata     = rdata;
  assign bus.stall_timeout = timeout_flag;

  // Readout shows the selected counter after this cycle's update, so it is
  // taken from the next-state values rather than the current registers.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.cnt_clr)                         src_nxt[i] = '0;
      else if (bus.stallreq[i] && !flush)      src_nxt[i] = sat_inc(src_cnt[i]);
      else                                     src_nxt[i] = src_cnt[i];
    end
    if (bus.cnt_clr)       total_nxt = '0;
    else if (stall[0])     total_nxt = sat_inc(total_cnt);
    else                   total_nxt = total_cnt;
    rdata_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(bus.cnt_sel) == i) rdata_nxt = src_nxt[i];
    end
    if (int'(bus.cnt_sel) == NUM_SRC) rdata_nxt = total_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt     <= '0;
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
      total_cnt    <= '0;
      rdata        <= '0;
      for (int i = 0; i < NUM_SRC; i++) src_cnt[i] <= '0;
    end else begin
      if (bus.except_en)        hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;

      for (int i = 0; i < NUM_SRC; i++) src_cnt[i] <= src_nxt[i];
      total_cnt <= total_nxt;
      rdata     <= rdata_nxt;

      // stall[0] is already low during flush, so one test covers both restarts.
      if (bus.cnt_clr) begin
        wd_cnt       <= '0;
        timeout_flag <= 1'b0;
      end else if (!stall[0]) begin
        wd_cnt <= '0;
      end else begin
        if (wd_cnt != WD_MAX)         wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_MAX - 1'b1)  timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: one default instance and one with
// FLUSH_CYCLES=3, TIMEOUT=8, CNT_WIDTH=4.
module tb_pipe_ctrl_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_gen_if #(.NUM_STAGES(6), .NUM_SRC(4), .CNT_WIDTH(32)) ia ();
  pipe_ctrl_gen_if #(.NUM_STAGES(6), .NUM_SRC(4), .CNT_WIDTH(4))  ib ();

  pipe_ctrl_gen u_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ia.slave)
  );

  pipe_ctrl_gen #(
    .CNT_WIDTH    (4),
    .TIMEOUT      (8),
    .FLUSH_CYCLES (3)
  ) u_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ib.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ia.stallreq  = 4'hF;
    ia.except_en = 1'b1;
    ib.stallreq  = 4'hF;
    #2;
    total++;
    if (ia.stall !== 6'b0) begin
      bad++; $display("FAIL reset_stall_a: got %b want %b", ia.stall, 6'b0);
    end
    total++;
    if (ia.flush !== 1'b0) begin
      bad++; $display("FAIL reset_flush_a: got %b want 0", ia.flush);
    end
    total++;
    if (ib.stall !== 6'b0) begin
      bad++; $display("FAIL reset_stall_b: got %b want %b", ib.stall, 6'b0);
    end
    tick();
    total++;
    if (ia.cnt_rdata !== 32'd0) begin
      bad++; $display("FAIL reset_rdata_a: got %0d want 0", ia.cnt_rdata);
    end
    total++;
    if (ib.stall_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_timeout_b: got %b want 0", ib.stall_timeout);
    end
    ia.stallreq  = 4'h0;
    ia.except_en = 1'b0;
    ib.stallreq  = 4'h0;
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_stall_merge;
    logic [3:0] req_v [4];
    logic [5:0] exp_v [4];
    req_v[0] = 4'b0001; exp_v[0] = 6'b000111;
    req_v[1] = 4'b0011; exp_v[1] = 6'b001111;
    req_v[2] = 4'b1001; exp_v[2] = 6'b111111;
    req_v[3] = 4'b0000; exp_v[3] = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      ia.stallreq = req_v[i];
      #1;
      total++;
      if (ia.stall !== exp_v[i] || ia.flush !== 1'b0) begin
        bad++;
        $display("FAIL stall_merge[%0d]: req=%b got stall=%b flush=%b want stall=%b flush=0",
                 i, req_v[i], ia.stall, ia.flush, exp_v[i]);
      end
    end
    ia.stallreq = 4'b0000;
    tick();
  endtask

  task automatic test_flush_priority;
    ia.cnt_clr = 1'b1;
    tick();
    ia.cnt_clr   = 1'b0;
    ia.stallreq  = 4'b0010;
    ia.except_en = 1'b1;
    #1;
    total++;
    if (ia.flush !== 1'b1 || ia.stall !== 6'b0) begin
      bad++; $display("FAIL flush_beats_stall: got flush=%b stall=%b want flush=1 stall=000000",
                      ia.flush, ia.stall);
    end
    tick();
    ia.except_en = 1'b0;
    #1;
    total++;
    if (ia.flush !== 1'b0 || ia.stall !== 6'b001111) begin
      bad++; $display("FAIL flush_single_cycle: got flush=%b stall=%b want flush=0 stall=001111",
                      ia.flush, ia.stall);
    end
    ia.stallreq = 4'b0000;
    ia.cnt_sel  = 3'd1;
    tick();
    total++;
    if (ia.cnt_rdata !== 32'd0) begin
      bad++; $display("FAIL src1_no_count_on_flush: got %0d want 0", ia.cnt_rdata);
    end
    ia.cnt_sel = 3'd4;
    tick();
    total++;
    if (ia.cnt_rdata !== 32'd0) begin
      bad++; $display("FAIL total_no_count_on_flush: got %0d want 0", ia.cnt_rdata);
    end
  endtask

  task automatic test_flush_hold;
    logic exp_f [4];
    exp_f[0] = 1'b1; exp_f[1] = 1'b1; exp_f[2] = 1'b1; exp_f[3] = 1'b0;
    ib.except_en = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ib.flush !== exp_f[c]) begin
        bad++; $display("FAIL flush_hold_c%0d: got %b want %b", c, ib.flush, exp_f[c]);
      end
      tick();
      ib.except_en = 1'b0;
    end
    // Restart from the second flush cycle of a new hold.
    ib.except_en = 1'b1;
    tick();
    ib.stallreq = 4'b0001;
    #1;
    total++;
    if (ib.flush !== 1'b1 || ib.stall !== 6'b0) begin
      bad++; $display("FAIL flush_hold_stall: got flush=%b stall=%b want flush=1 stall=000000",
                      ib.flush, ib.stall);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      ib.except_en = 1'b0;
      ib.stallreq  = 4'b0000;
      #1;
      total++;
      if (ib.flush !== exp_f[c]) begin
        bad++; $display("FAIL flush_restart_c%0d: got %b want %b", c, ib.flush, exp_f[c]);
      end
      if (c == 0) ib.except_en = 1'b1;
    end
    ib.except_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_counters;
    logic [2:0]  sel_v [5];
    logic [31:0] exp_v [5];
    sel_v[0] = 3'd2; exp_v[0] = 32'd10;
    sel_v[1] = 3'd4; exp_v[1] = 32'd10;
    sel_v[2] = 3'd0; exp_v[2] = 32'd0;
    sel_v[3] = 3'd5; exp_v[3] = 32'd0;
    sel_v[4] = 3'd3; exp_v[4] = 32'd0;
    ia.cnt_clr = 1'b1;
    tick();
    ia.cnt_clr  = 1'b0;
    ia.stallreq = 4'b0100;
    repeat (10) tick();
    ia.stallreq = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      ia.cnt_sel = sel_v[i];
      tick();
      total++;
      if (ia.cnt_rdata !== exp_v[i]) begin
        bad++; $display("FAIL cnt_read_sel%0d: got %0d want %0d", sel_v[i], ia.cnt_rdata, exp_v[i]);
      end
    end
    ia.stallreq = 4'b0100;
    ia.cnt_clr  = 1'b1;
    ia.cnt_sel  = 3'd2;
    tick();
    total++;
    if (ia.cnt_rdata !== 32'd0) begin
      bad++; $display("FAIL cnt_clr_wins: got %0d want 0", ia.cnt_rdata);
    end
    ia.cnt_clr  = 1'b0;
    ia.stallreq = 4'b0000;
    ia.cnt_sel  = 3'd4;
    tick();
    total++;
    if (ia.cnt_rdata !== 32'd0) begin
      bad++; $display("FAIL cnt_clr_total: got %0d want 0", ia.cnt_rdata);
    end
  endtask

  task automatic test_watchdog;
    ib.cnt_clr = 1'b1;
    tick();
    ib.cnt_clr  = 1'b0;
    ib.stallreq = 4'b0001;
    repeat (7) tick();
    total++;
    if (ib.stall_timeout !== 1'b0) begin
      bad++; $display("FAIL wd_7_cycles: got %b want 0", ib.stall_timeout);
    end
    ib.stallreq = 4'b0000;
    tick();
    ib.stallreq = 4'b0001;
    repeat (7) tick();
    total++;
    if (ib.stall_timeout !== 1'b0) begin
      bad++; $display("FAIL wd_restart: got %b want 0", ib.stall_timeout);
    end
    tick();
    total++;
    if (ib.stall_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_8_cycles: got %b want 1", ib.stall_timeout);
    end
    ib.stallreq = 4'b0000;
    repeat (2) tick();
    total++;
    if (ib.stall_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_sticky: got %b want 1", ib.stall_timeout);
    end
    ib.cnt_clr = 1'b1;
    tick();
    ib.cnt_clr = 1'b0;
    total++;
    if (ib.stall_timeout !== 1'b0) begin
      bad++; $display("FAIL wd_clear: got %b want 0", ib.stall_timeout);
    end
  endtask

  task automatic test_saturation_and_reset;
    ib.cnt_clr = 1'b1;
    tick();
    ib.cnt_clr  = 1'b0;
    ib.cnt_sel  = 3'd4;
    ib.stallreq = 4'b0001;
    repeat (20) tick();
    total++;
    if (ib.cnt_rdata !== 4'd15) begin
      bad++; $display("FAIL total_saturate: got %0d want 15", ib.cnt_rdata);
    end
    ib.cnt_sel = 3'd0;
    tick();
    total++;
    if (ib.cnt_rdata !== 4'd15) begin
      bad++; $display("FAIL src0_saturate: got %0d want 15", ib.cnt_rdata);
    end
    total++;
    if (ib.stall !== 6'b000111 || ib.stall_timeout !== 1'b1) begin
      bad++; $display("FAIL pre_reset_state: got stall=%b timeout=%b want stall=000111 timeout=1",
                      ib.stall, ib.stall_timeout);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (ib.stall !== 6'b0 || ib.flush !== 1'b0) begin
      bad++; $display("FAIL async_reset_stall: got stall=%b flush=%b want 000000/0", ib.stall, ib.flush);
    end
    total++;
    if (ib.cnt_rdata !== 4'd0 || ib.stall_timeout !== 1'b0) begin
      bad++; $display("FAIL async_reset_regs: got rdata=%0d timeout=%b want 0/0",
                      ib.cnt_rdata, ib.stall_timeout);
    end
    ib.stallreq = 4'b0000;
    ib.cnt_sel  = 3'd4;
    #2 resetn = 1'b1;
    tick();
    total++;
    if (ib.cnt_rdata !== 4'd0) begin
      bad++; $display("FAIL post_reset_total: got %0d want 0", ib.cnt_rdata);
    end
  endtask

  initial begin
    ia.except_en = 1'b0; ia.stallreq = 4'h0; ia.cnt_clr = 1'b0; ia.cnt_sel = 3'd0;
    ib.except_en = 1'b0; ib.stallreq = 4'h0; ib.cnt_clr = 1'b0; ib.cnt_sel = 3'd0;
    test_reset();
    test_stall_merge();
    test_flush_priority();
    test_flush_hold();
    test_counters();
    test_watchdog();
    test_saturation_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipeline controller for the in-order LoongArch core, the next generation of the fixed 6-stage stall/flush controller. It merges NUM_SRC stall requests, each bound to a pipeline stage by parameter, into a thermometer stall vector, and generates a flush that can be held for several cycles. It also keeps per-source and total stall-cycle counters plus a stall watchdog for debug and performance visibility. It sits in the core top beside the stage modules and drives their stall/flush inputs.

Parameters:
NUM_STAGES, 6, pipeline stages; stall bit 0 = PC, bit NUM_STAGES-1 = last stage
NUM_SRC, 4, number of stall request sources
SRC_STAGE, 12'hB1A, packed 3-bit stage index per source; src i uses bits [3i+2:3i]; default src0->2, src1->3, src2->4, src3->5
CNT_WIDTH, 32, width of the stall-cycle counters
TIMEOUT, 1024, consecutive stall cycles that trip the watchdog (>=2)
FLUSH_CYCLES, 1, cycles flush is asserted per exception (>=1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
except_en  in  1  exception/ertn redirect request from the commit stage
stallreq  in  NUM_SRC  stall requests; bit i = source i
cnt_clr  in  1  synchronous clear of all counters and the watchdog flag
cnt_sel  in  $clog2(NUM_SRC+1)  counter select; NUM_SRC selects the total counter
stall  out  NUM_STAGES  per-stage stall vector
flush  out  1  pipeline flush
cnt_rdata  out  CNT_WIDTH  selected counter value
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (resetn low, asynchronous): all counters 0, flush hold counter 0, watchdog counter 0, stall_timeout 0. stall and flush are forced 0 while resetn is low.
- Stall merge (combinational, same cycle): k = max SRC_STAGE index over asserted stallreq bits. stall[k:0] = 1, upper bits = 0. If no request is asserted, stall = 0. An index >= NUM_STAGES clamps to NUM_STAGES-1.
- Flush: flush = except_en | (hold_cnt != 0), combinational. The first cycle of flush appears in the same cycle as except_en.
  - On except_en, hold_cnt loads FLUSH_CYCLES-1. Otherwise hold_cnt decrements toward 0.
  - except_en during a hold restarts the load.
  - With FLUSH_CYCLES=1 there is no hold.
- Priority: whenever flush = 1, stall = 0 regardless of stallreq (flush beats stall).
- Source counters: cnt[i] increments in every cycle where stallreq[i] = 1 and flush = 0. Multiple sources count simultaneously.
- Total counter: increments in every cycle where stall[0] = 1.
- Counter width: all counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- Watchdog: wd_cnt increments while stall[0] = 1. It resets to 0 in any cycle with stall[0] = 0 or flush = 1. When the increment reaches TIMEOUT, stall_timeout is set. The flag stays set until cnt_clr or reset. wd_cnt saturates at TIMEOUT.
- cnt_clr: all counters, wd_cnt and stall_timeout go to 0 on the next edge. If cnt_clr coincides with an increment, the clear wins and the result is 0.
- cnt_rdata: registered read. The value shown is the counter selected by the previous cycle's cnt_sel, sampled after that cycle's update. A cnt_sel value > NUM_SRC reads 0.
- Implementation: no latches. Only the cnt_rdata register is read out.

Test Plan:
1. Defaults, stallreq=4'b0001 -> stall=6'b000111. stallreq=4'b0011 -> 6'b001111. stallreq=4'b1001 -> 6'b111111. stallreq=0 -> 6'b000000.
2. stallreq=4'b0010 with except_en=1 in the same cycle -> flush=1, stall=0. Source 1 counter does not increment that cycle.
3. FLUSH_CYCLES=3: except_en pulsed for 1 cycle -> flush high 3 cycles. A second except_en pulse in hold cycle 2 -> flush stays high 3 cycles from that pulse.
4. stallreq=4'b0100 for 10 cycles, then cnt_sel=2 -> cnt_rdata=10. cnt_sel=4 -> 10. cnt_sel=0 -> 0. Then cnt_clr pulse -> all reads 0.
5. TIMEOUT=8, stallreq[0] held 7 cycles -> stall_timeout=0. Held 8 cycles -> stall_timeout=1 and stays 1 after stallreq drops; cleared by cnt_clr.
6. CNT_WIDTH=4, stall for 20 cycles -> total counter reads 15 (saturated). resetn dropped mid-stall -> stall=0 and counters 0 immediately, without waiting for a clock edge.
